// File: rtl/prog_ctr_pkg.sv
// Shared types for the fetch-stage program counter.
// Op encodings decoded by prog_ctr_stack.
package prog_ctr_pkg;

    typedef enum logic [2:0] {
        PC_INC   = 3'd0,
        PC_BRREL = 3'd1,
        PC_BRABS = 3'd2,
        PC_CALL  = 3'd3,
        PC_RET   = 3'd4,
        PC_HALT  = 3'd5
    } pc_op_t;

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO: register array indexed by an occupancy count.
// Overflowing pushes and underflowing pops are dropped here.
module ret_stack #(
    parameter int W     = 10,
    parameter int DEPTH = 4
) (
    input  logic                       Clk,
    input  logic                       Reset_n,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               data_in,
    output logic [W-1:0]               top,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] depth
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [DW-1:0] cnt;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;

    assign wr_idx = AW'(cnt);
    assign rd_idx = AW'(cnt - DW'(1));
    assign full   = (cnt == DW'(DEPTH));
    assign empty  = (cnt == '0);
    assign depth  = cnt;
    assign top    = mem[rd_idx];

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (push && !full) begin
            cnt <= cnt + DW'(1);
        end else if (pop && !empty) begin
            cnt <= cnt - DW'(1);
        end
    end

    // Contents are not reset; only the count decides what is valid.
    always_ff @(posedge Clk) begin
        if (!clear && push && !full) begin
            mem[wr_idx] <= data_in;
        end
    end

endmodule

// File: rtl/prog_ctr_stack.sv
// Fetch-stage program counter with branches, call/return stack,
// start vector, stall hold and halt.
module prog_ctr_stack
    import prog_ctr_pkg::*;
#(
    parameter int L     = 10,
    parameter int DEPTH = 4
) (
    input  logic                       Clk,
    input  logic                       Reset_n,
    input  logic                       Start,
    input  logic [L-1:0]               StartAddr,
    input  logic                       Stall,
    input  logic [2:0]                 Op,
    input  logic                       ALUFlag,
    input  logic [L-1:0]               Target,
    output logic [L-1:0]               ProgCtr,
    output logic                       Halted,
    output logic [$clog2(DEPTH+1)-1:0] StackDepth,
    output logic                       StackErr
);

    pc_op_t       op;
    logic         run;
    logic [L-1:0] pc_inc;
    logic [L-1:0] pc_nxt;
    logic         push;
    logic         pop;
    logic         halt_set;
    logic         err_set;
    logic [L-1:0] top;
    logic         full;
    logic         empty;

    assign op     = pc_op_t'(Op);
    assign run    = !Start && !Halted && !Stall;
    assign pc_inc = ProgCtr + L'(1);

    // Unknown encodings fall through to the default increment.
    always_comb begin
        pc_nxt   = pc_inc;
        push     = 1'b0;
        pop      = 1'b0;
        halt_set = 1'b0;
        err_set  = 1'b0;
        case (op)
            PC_BRREL: if (ALUFlag) pc_nxt = ProgCtr + Target;
            PC_BRABS: if (ALUFlag) pc_nxt = Target;
            PC_CALL: begin
                if (!full) begin
                    push   = 1'b1;
                    pc_nxt = Target;
                end else begin
                    err_set = 1'b1;
                end
            end
            PC_RET: begin
                if (!empty) begin
                    pop    = 1'b1;
                    pc_nxt = top;
                end else begin
                    err_set = 1'b1;
                end
            end
            PC_HALT: begin
                halt_set = 1'b1;
                pc_nxt   = ProgCtr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ProgCtr  <= '0;
            Halted   <= 1'b0;
            StackErr <= 1'b0;
        end else if (Start) begin
            ProgCtr  <= StartAddr;
            Halted   <= 1'b0;
            StackErr <= 1'b0;
        end else if (run) begin
            ProgCtr <= pc_nxt;
            if (halt_set) Halted <= 1'b1;
            if (err_set) StackErr <= 1'b1;
        end
    end

    ret_stack #(
        .W     (L),
        .DEPTH (DEPTH)
    ) u_stack (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .clear   (Start),
        .push    (run && push),
        .pop     (run && pop),
        .data_in (pc_inc),
        .top     (top),
        .full    (full),
        .empty   (empty),
        .depth   (StackDepth)
    );

endmodule

// File: tb/tb_prog_ctr_stack.sv
// Bench for prog_ctr_stack: queue-based reference model,
// directed scenarios plus randomized op streams.
module tb_prog_ctr_stack;

    localparam int L     = 10;
    localparam int DEPTH = 4;
    localparam int DW    = $clog2(DEPTH + 1);

    logic          Clk = 1'b0;
    logic          Reset_n;
    logic          Start;
    logic [L-1:0]  StartAddr;
    logic          Stall;
    logic [2:0]    Op;
    logic          ALUFlag;
    logic [L-1:0]  Target;
    logic [L-1:0]  ProgCtr;
    logic          Halted;
    logic [DW-1:0] StackDepth;
    logic          StackErr;

    int tests = 0;
    int fails = 0;

    logic [L-1:0] m_pc;
    logic         m_halt;
    logic         m_err;
    logic [L-1:0] m_stk [$];

    prog_ctr_stack #(.L(L), .DEPTH(DEPTH)) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .Start      (Start),
        .StartAddr  (StartAddr),
        .Stall      (Stall),
        .Op         (Op),
        .ALUFlag    (ALUFlag),
        .Target     (Target),
        .ProgCtr    (ProgCtr),
        .Halted     (Halted),
        .StackDepth (StackDepth),
        .StackErr   (StackErr)
    );

    always #5 Clk = ~Clk;

    // Reference model: inputs are stable at the edge it samples.
    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            m_pc   = '0;
            m_halt = 1'b0;
            m_err  = 1'b0;
            m_stk.delete();
        end else if (Start) begin
            m_pc   = StartAddr;
            m_halt = 1'b0;
            m_err  = 1'b0;
            m_stk.delete();
        end else if (!m_halt && !Stall) begin
            case (Op)
                3'd1: m_pc = ALUFlag ? m_pc + Target : m_pc + 1'b1;
                3'd2: m_pc = ALUFlag ? Target : m_pc + 1'b1;
                3'd3: begin
                    if (m_stk.size() < DEPTH) begin
                        m_stk.push_back(m_pc + 1'b1);
                        m_pc = Target;
                    end else begin
                        m_pc  = m_pc + 1'b1;
                        m_err = 1'b1;
                    end
                end
                3'd4: begin
                    if (m_stk.size() > 0) begin
                        m_pc = m_stk.pop_back();
                    end else begin
                        m_pc  = m_pc + 1'b1;
                        m_err = 1'b1;
                    end
                end
                3'd5: m_halt = 1'b1;
                default: m_pc = m_pc + 1'b1;
            endcase
        end
    end

    always @(negedge Clk) begin
        tests++;
        if (ProgCtr !== m_pc || Halted !== m_halt || StackErr !== m_err ||
            StackDepth !== DW'(m_stk.size())) begin
            fails++;
            $display("FAIL model t=%0t pc=%0d/%0d halt=%0b/%0b err=%0b/%0b depth=%0d/%0d",
                     $time, ProgCtr, m_pc, Halted, m_halt, StackErr, m_err,
                     StackDepth, m_stk.size());
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs, return just after the consuming edge.
    task automatic cyc(input logic st, input int sa, input logic sl,
                       input int op, input logic fl, input int tg);
        Start     = st;
        StartAddr = L'(sa);
        Stall     = sl;
        Op        = 3'(op);
        ALUFlag   = fl;
        Target    = L'(tg);
        @(posedge Clk);
        #2;
    endtask

    task automatic inc(); cyc(0, 0, 0, 0, 0, 0); endtask
    task automatic ld(input int a); cyc(1, a, 0, 0, 0, 0); endtask

    initial begin
        Reset_n = 1'b0;
        Start = 0; StartAddr = 0; Stall = 0; Op = 0; ALUFlag = 0; Target = 0;
        @(posedge Clk); #2;
        chk("reset_pc", int'(ProgCtr), 0);
        chk("reset_depth", int'(StackDepth), 0);
        chk("reset_flags", int'({Halted, StackErr}), 0);
        Reset_n = 1'b1;
        repeat (5) inc();
        chk("inc5", int'(ProgCtr), 5);
        Reset_n = 1'b0;
        #1;
        chk("async_reset", int'(ProgCtr), 0);
        @(posedge Clk); #2;
        Reset_n = 1'b1;

        ld(8);
        cyc(0, 0, 0, 1, 1, 'h3FD);
        chk("brrel_taken", int'(ProgCtr), 5);
        ld(8);
        cyc(0, 0, 0, 1, 0, 'h3FD);
        chk("brrel_not", int'(ProgCtr), 9);
        cyc(0, 0, 0, 2, 1, 700);
        chk("brabs_taken", int'(ProgCtr), 700);
        ld(1023);
        inc();
        chk("wrap", int'(ProgCtr), 0);

        ld(20);
        cyc(0, 0, 0, 3, 0, 100);
        chk("call_pc", int'(ProgCtr), 100);
        chk("call_depth", int'(StackDepth), 1);
        cyc(0, 0, 0, 4, 0, 0);
        chk("ret_pc", int'(ProgCtr), 21);
        chk("ret_depth", int'(StackDepth), 0);

        ld(0);
        for (int i = 1; i <= 4; i++) cyc(0, 0, 0, 3, 0, 10 * i);
        chk("nest_pc", int'(ProgCtr), 40);
        cyc(0, 0, 0, 3, 0, 50);
        chk("ovf_pc", int'(ProgCtr), 41);
        chk("ovf_err", int'(StackErr), 1);
        chk("ovf_depth", int'(StackDepth), 4);
        for (int i = 3; i >= 0; i--) begin
            cyc(0, 0, 0, 4, 0, 0);
            chk("unwind", int'(ProgCtr), (i == 0) ? 1 : 10 * i + 1);
        end
        cyc(0, 0, 0, 4, 0, 0);
        chk("udf_pc", int'(ProgCtr), 2);
        chk("udf_depth", int'(StackDepth), 0);

        repeat (3) ld(300);
        chk("start_hold", int'(ProgCtr), 300);
        chk("start_clr_err", int'(StackErr), 0);
        inc();
        inc();
        chk("resume", int'(ProgCtr), 302);
        repeat (2) cyc(0, 0, 1, 0, 1, 5);
        chk("stall", int'(ProgCtr), 302);

        ld(50);
        cyc(0, 0, 0, 5, 0, 0);
        chk("halt_flag", int'(Halted), 1);
        repeat (10) cyc(0, 0, 0, $urandom_range(0, 7), 1, $urandom);
        chk("halt_pc", int'(ProgCtr), 50);
        ld(0);
        chk("unhalt", int'({Halted, ProgCtr}), 0);

        // Weighted random traffic: bias toward CALL/RET to exercise limits.
        for (int n = 0; n < 3000; n++) begin
            int r;
            int op;
            r  = $urandom_range(0, 99);
            op = (r < 25) ? 3 : (r < 50) ? 4 : (r < 52) ? 5 :
                 $urandom_range(0, 7);
            if ($urandom_range(0, 299) == 0) begin
                Reset_n = 1'b0;
                #1;
                Reset_n = 1'b1;
            end
            cyc($urandom_range(0, 39) == 0, $urandom,
                $urandom_range(0, 7) == 0, op, $urandom_range(0, 1),
                $urandom);
        end

        @(negedge Clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/prog_ctr_stack.md
# prog_ctr_stack

Parametrised successor to the processor's program counter. Supports incremental fetch, conditional relative and absolute branches, and subroutine call/return through an internal return-address stack. It also provides a loadable start vector for running multiple programs, a stall hold, and a halt state. It sits in the fetch stage: its `ProgCtr` output addresses the instruction ROM, and control decode plus the ALU flag drive its inputs.

## Interface
Parameters:
- `L`, 10, PC width; must equal the instruction ROM address width.
- `DEPTH`, 4, return-stack entries (≥1).

Ports:
- `Clk`  in  1  clock; all state changes on posedge.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `Start`  in  1  load `StartAddr`, clear stack/halt/error, hold while high.
- `StartAddr`  in  L  program entry vector.
- `Stall`  in  1  hold all state this cycle.
- `Op`  in  3  `pc_op_t`: `PC_INC`, `PC_BRREL`, `PC_BRABS`, `PC_CALL`, `PC_RET`, `PC_HALT`.
- `ALUFlag`  in  1  condition for `PC_BRREL`/`PC_BRABS`.
- `Target`  in  L  branch offset (REL) or address (ABS/CALL).
- `ProgCtr`  out  L  program counter register.
- `Halted`  out  1  PC frozen by `PC_HALT`.
- `StackDepth`  out  $clog2(DEPTH+1)  valid stack entries.
- `StackErr`  out  1  sticky overflow/underflow flag.

## Operation
- Per-cycle priority: `Reset_n` low > `Start` > `Halted` > `Stall` > `Op`.
- `Start`=1: `ProgCtr`←`StartAddr`, depth←0, `Halted`←0, `StackErr`←0. Repeats every cycle while high. Fetch resumes the cycle after `Start` falls.
- `Halted`=1: all state held and `Op` ignored. Only `Start` or reset exits.
- `Stall`=1: all state held.
- `PC_INC`: PC←PC+1.
- `PC_BRREL`: if `ALUFlag`, PC←PC+`Target`, else PC+1. `Target` is two's complement; the sum wraps mod 2^L.
- `PC_BRABS`: if `ALUFlag`, PC←`Target`, else PC+1.
- `PC_CALL` (unconditional): if not full, push PC+1 and set PC←`Target`. If full, no push, PC←PC+1, `StackErr`←1.
- `PC_RET` (unconditional): if not empty, pop and set PC←top. If empty, PC←PC+1, `StackErr`←1.
- `PC_HALT`: `Halted`←1 and PC unchanged.
- Undefined `Op` encodings behave as `PC_INC`.
- All PC+1 arithmetic wraps from 2^L−1 to 0.

## Timing
- Reset values: `ProgCtr`=0, `Halted`=0, `StackDepth`=0, `StackErr`=0. Reset is asserted immediately (async) and released synchronously. Reset mid-call/return discards the stack.
- `ProgCtr` is registered. Next-PC is combinational from `Op`/`ALUFlag`/`Target` in the same cycle, so every op has one-cycle latency.
- A push and a pop never occur in the same cycle. Call then return on consecutive cycles returns to call-site+1.
- Stack contents are not reset; only depth is. Contents above depth are don't-care.
- `StackErr` persists until `Start` or reset.

## Structure
- `prog_ctr_pkg`: `pc_op_t` enum (3-bit: INC=0, BRREL=1, BRABS=2, CALL=3, RET=4, HALT=5).
- Sub-module `ret_stack #(W, DEPTH)`: LIFO with push/pop/data_in/top/full/empty/depth. Register array plus pointer; push when full and pop when empty are ignored internally.
- Top level holds the PC register, next-PC mux, halt flag, and error flag.

## Test plan
- Reset then 5× `PC_INC` → `ProgCtr`=5. Assert `Reset_n` low mid-run → `ProgCtr`=0 before the next edge.
- At PC=8, `PC_BRREL` with `Target`=−3 (L=10: 10'h3FD): `ALUFlag`=1 → 5; with `ALUFlag`=0 → 9. At PC=1023, `PC_INC` → 0.
- At PC=20, `PC_CALL` `Target`=100 → PC=100, depth=1. Then `PC_RET` → 21, depth=0.
- DEPTH=4, five nested calls → fifth leaves PC=last+1, `StackErr`=1, depth=4. Four returns unwind in LIFO order. A fifth return → PC+1, depth stays 0.
- `Start`=1, `StartAddr`=300 for 3 cycles → PC=300, held. Release, then 2× `PC_INC` → 302. `Stall`=1 for 2 cycles → PC held at 302.
- `PC_HALT` at PC=50 → `Halted`=1, PC=50 for 10 cycles regardless of `Op`. `Start` with `StartAddr`=0 → `Halted`=0, PC=0.
